fpu_regfile_fcsr: RTL and testbench

Responder side of the FPU register interface. Holds the 32 x 32-bit floating-point register file and the fcsr state (frm, fflags). It serves the FPU's operand reads (f_rs1/f_rs2) and accepts its write-back (FPU result or load data, selected by f_LW). It accumulates the FPU's exception flags (f_flags) into sticky fflags and resolves the rounding mode returned to the FPU on f_frm_out.

---
 rtl/fpu_regfile_fcsr.sv | 120 ++++++++++++
 tb/tb_fpu_regfile_fcsr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_regfile_fcsr.sv
// FPU register file and fcsr (frm, fflags) holder.
// Serves combinational operand reads with write-through bypass, CSR read-modify-write and sticky flag accumulation.
module fpu_regfile_fcsr #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        f_rs1,
    input  logic [4:0]        f_rs2,
    input  logic [4:0]        f_rd,
    input  logic              f_wen,
    input  logic              f_LW,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] FPU_out,
    input  logic [4:0]        f_flags,
    input  logic              flags_valid,
    input  logic [2:0]        frm,
    input  logic [1:0]        csr_op,
    input  logic [1:0]        csr_sel,
    input  logic [7:0]        csr_wdata,
    output logic [7:0]        csr_rdata,
    output logic [DATA_W-1:0] f_rs1_data,
    output logic [DATA_W-1:0] f_rs2_data,
    output logic [2:0]        f_frm_out,
    output logic              rm_illegal,
    output logic [4:0]        fflags_out
);

    localparam logic [1:0] SEL_FFLAGS = 2'b00;
    localparam logic [1:0] SEL_FRM    = 2'b01;
    localparam logic [1:0] SEL_FCSR   = 2'b10;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0] RM_DYN = 3'b111;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] wdata;

    logic [2:0] frm_q, frm_d;
    logic [4:0] fflags_q, fflags_d;
    logic [4:0] fflags_csr;
    logic [7:0] csr_res;

    function automatic logic [7:0] csr_apply(input logic [1:0] op,
                                             input logic [7:0] old,
                                             input logic [7:0] wd);
        case (op)
            OP_WRITE: return wd;
            OP_SET:   return old | wd;
            OP_CLEAR: return old & ~wd;
            default:  return old;
        endcase
    endfunction

    assign wdata = f_LW ? load_data : FPU_out;

    // Bypass lets a consumer see the value being written back this same cycle.
    assign f_rs1_data = (f_wen && (f_rd == f_rs1)) ? wdata : regs_q[f_rs1];
    assign f_rs2_data = (f_wen && (f_rd == f_rs2)) ? wdata : regs_q[f_rs2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (f_wen) begin
            regs_q[f_rd] <= wdata;
        end
    end

    assign f_frm_out  = (frm == RM_DYN) ? frm_q : frm;
    assign rm_illegal = (f_frm_out >= 3'b101);
    assign fflags_out = fflags_q;

    // Only the selected field's width of csr_wdata takes part in the update.
    always_comb begin
        csr_rdata  = 8'h00;
        csr_res    = 8'h00;
        fflags_csr = fflags_q;
        frm_d      = frm_q;
        case (csr_sel)
            SEL_FFLAGS: begin
                csr_rdata  = {3'b000, fflags_q};
                csr_res    = csr_apply(csr_op, {3'b000, fflags_q}, {3'b000, csr_wdata[4:0]});
                fflags_csr = csr_res[4:0];
            end
            SEL_FRM: begin
                csr_rdata = {5'b00000, frm_q};
                csr_res   = csr_apply(csr_op, {5'b00000, frm_q}, {5'b00000, csr_wdata[2:0]});
                frm_d     = csr_res[2:0];
            end
            SEL_FCSR: begin
                csr_rdata  = {frm_q, fflags_q};
                csr_res    = csr_apply(csr_op, {frm_q, fflags_q}, csr_wdata);
                frm_d      = csr_res[7:5];
                fflags_csr = csr_res[4:0];
            end
            default: begin
                csr_rdata = 8'h00;
            end
        endcase
        // Flags raised this cycle survive a concurrent CSR write or clear.
        fflags_d = fflags_csr | (flags_valid ? f_flags : 5'b00000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_q    <= 3'b000;
            fflags_q <= 5'b00000;
        end else begin
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
        end
    end

endmodule

// File: tb/tb_fpu_regfile_fcsr.sv
// Directed bench for fpu_regfile_fcsr: register file, bypass, rounding mode, CSR ops and sticky flags.
module tb_fpu_regfile_fcsr;

    logic        clk;
    logic        rst;
    logic [4:0]  f_rs1, f_rs2, f_rd;
    logic        f_wen, f_LW;
    logic [31:0] load_data, FPU_out;
    logic [4:0]  f_flags;
    logic        flags_valid;
    logic [2:0]  frm;
    logic [1:0]  csr_op, csr_sel;
    logic [7:0]  csr_wdata;
    logic [7:0]  csr_rdata;
    logic [31:0] f_rs1_data, f_rs2_data;
    logic [2:0]  f_frm_out;
    logic        rm_illegal;
    logic [4:0]  fflags_out;

    int checks;
    int failures;

    fpu_regfile_fcsr #(.NREGS(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_rs1       (f_rs1),
        .f_rs2       (f_rs2),
        .f_rd        (f_rd),
        .f_wen       (f_wen),
        .f_LW        (f_LW),
        .load_data   (load_data),
        .FPU_out     (FPU_out),
        .f_flags     (f_flags),
        .flags_valid (flags_valid),
        .frm         (frm),
        .csr_op      (csr_op),
        .csr_sel     (csr_sel),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .f_rs1_data  (f_rs1_data),
        .f_rs2_data  (f_rs2_data),
        .f_frm_out   (f_frm_out),
        .rm_illegal  (rm_illegal),
        .fflags_out  (fflags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_wen       = 1'b0;
        f_LW        = 1'b0;
        csr_op      = 2'b00;
        flags_valid = 1'b0;
        f_flags     = 5'b00000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        f_rs1 = 5'd0; f_rs2 = 5'd0; f_rd = 5'd0;
        load_data = 32'h0; FPU_out = 32'h0;
        frm = 3'b000; csr_sel = 2'b00; csr_wdata = 8'h00;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 32; i++) begin
            f_rs1 = 5'(i);
            f_rs2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rs1_r%0d", i), f_rs1_data, 32'h0);
            chk($sformatf("rst_rs2_r%0d", 31 - i), f_rs2_data, 32'h0);
        end
        csr_sel = 2'b10; #1;
        chk("rst_fcsr", {24'h0, csr_rdata}, 32'h00);
        chk("rst_fflags_out", {27'h0, fflags_out}, 32'h0);
        frm = 3'b111; #1;
        chk("rst_frm_dyn", {29'h0, f_frm_out}, 32'h0);
        chk("rst_rm_illegal", {31'h0, rm_illegal}, 32'h0);
        frm = 3'b000;

        // Bypass of load data
        f_wen = 1'b1; f_rd = 5'd3; f_LW = 1'b1;
        load_data = 32'h3F800000; FPU_out = 32'h40000000;
        f_rs1 = 5'd3; f_rs2 = 5'd4; #1;
        chk("bypass_rs1", f_rs1_data, 32'h3F800000);
        chk("nobypass_rs2", f_rs2_data, 32'h0);
        tick();
        f_wen = 1'b0; f_LW = 1'b0; #1;
        chk("stored_r3", f_rs1_data, 32'h3F800000);

        // f0 writable, FPU_out path
        f_wen = 1'b1; f_rd = 5'd0; f_LW = 1'b0; FPU_out = 32'hC0490FDB;
        tick();
        f_wen = 1'b0; f_rs1 = 5'd0; f_rs2 = 5'd0; #1;
        chk("f0_rs2", f_rs2_data, 32'hC0490FDB);
        chk("f0_rs1_same", f_rs1_data, 32'hC0490FDB);
        f_rs1 = 5'd3; #1;
        chk("r3_kept", f_rs1_data, 32'h3F800000);

        // frm CSR write, dynamic rounding resolution
        csr_op = 2'b01; csr_sel = 2'b01; csr_wdata = 8'h02; #1;
        chk("frm_rdata_old", {24'h0, csr_rdata}, 32'h00);
        tick();
        csr_op = 2'b00; frm = 3'b111; #1;
        chk("frm_dyn_010", {29'h0, f_frm_out}, 32'h2);
        chk("frm_dyn_legal", {31'h0, rm_illegal}, 32'h0);
        chk("frm_rdata_new", {24'h0, csr_rdata}, 32'h02);
        frm = 3'b101; #1;
        chk("frm_static_101", {29'h0, f_frm_out}, 32'h5);
        chk("frm_101_illegal", {31'h0, rm_illegal}, 32'h1);
        frm = 3'b110; #1;
        chk("frm_110_illegal", {31'h0, rm_illegal}, 32'h1);
        frm = 3'b100; #1;
        chk("frm_100_legal", {31'h0, rm_illegal}, 32'h0);

        // frm set then clear with extra wdata bits
        csr_op = 2'b10; csr_sel = 2'b01; csr_wdata = 8'h05;
        tick();
        csr_op = 2'b00; frm = 3'b111; #1;
        chk("frm_set_111", {29'h0, f_frm_out}, 32'h7);
        chk("frm_dyn_111_illegal", {31'h0, rm_illegal}, 32'h1);
        csr_op = 2'b11; csr_wdata = 8'hFD;
        tick();
        csr_op = 2'b00; #1;
        chk("frm_clear_010", {29'h0, f_frm_out}, 32'h2);

        // Sticky flag accumulation
        flags_valid = 1'b1; f_flags = 5'b00001;
        tick();
        tick();
        f_flags = 5'b10000;
        tick();
        flags_valid = 1'b0; f_flags = 5'b11111;
        #1;
        chk("fflags_sticky", {27'h0, fflags_out}, 32'h11);
        tick();
        chk("fflags_unqualified", {27'h0, fflags_out}, 32'h11);
        csr_sel = 2'b00; #1;
        chk("fflags_rdata", {24'h0, csr_rdata}, 32'h11);
        csr_sel = 2'b10; #1;
        chk("fcsr_rdata", {24'h0, csr_rdata}, 32'h51);

        // Clear with concurrent new flags
        csr_op = 2'b11; csr_sel = 2'b00; csr_wdata = 8'h1F;
        flags_valid = 1'b1; f_flags = 5'b00100; #1;
        chk("clear_rdata_pre", {24'h0, csr_rdata}, 32'h11);
        tick();
        idle(); #1;
        chk("clear_keeps_new", {27'h0, fflags_out}, 32'h04);

        // Full fcsr write plus reg5 write
        csr_op = 2'b01; csr_sel = 2'b10; csr_wdata = 8'h6A;
        f_wen = 1'b1; f_rd = 5'd5; f_LW = 1'b0; FPU_out = 32'h12345678;
        tick();
        idle(); frm = 3'b111; f_rs1 = 5'd5; #1;
        chk("fcsr_write", {24'h0, csr_rdata}, 32'h6A);
        chk("fcsr_frm_dyn", {29'h0, f_frm_out}, 32'h3);
        chk("fcsr_fflags", {27'h0, fflags_out}, 32'h0A);
        chk("r5_written", f_rs1_data, 32'h12345678);

        // Reserved selector
        csr_op = 2'b01; csr_sel = 2'b11; csr_wdata = 8'hFF; #1;
        chk("sel11_rdata", {24'h0, csr_rdata}, 32'h00);
        tick();
        csr_op = 2'b00; csr_sel = 2'b10; #1;
        chk("sel11_no_update", {24'h0, csr_rdata}, 32'h6A);

        // Reset priority over write, CSR and flags
        rst = 1'b1;
        f_wen = 1'b1; f_rd = 5'd5; FPU_out = 32'hDEADBEEF;
        csr_op = 2'b01; csr_sel = 2'b10; csr_wdata = 8'hFF;
        flags_valid = 1'b1; f_flags = 5'b11111;
        tick();
        rst = 1'b0; idle(); csr_sel = 2'b10; f_rs1 = 5'd5; f_rs2 = 5'd3; frm = 3'b111; #1;
        chk("rstmid_r5", f_rs1_data, 32'h0);
        chk("rstmid_r3", f_rs2_data, 32'h0);
        chk("rstmid_fcsr", {24'h0, csr_rdata}, 32'h00);
        chk("rstmid_fflags", {27'h0, fflags_out}, 32'h0);
        chk("rstmid_frm_dyn", {29'h0, f_frm_out}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
